sha1_channel_pool: RTL
======================

# sha1_channel_pool

Parametrised free-list allocator for SHA1 hash-engine channel IDs. After reset and a settle delay it loads a configurable subset of channel IDs into an internal FWFT free list. It hands IDs to the job dispatcher over a valid/ready port and takes them back from the result path. Compared with the fixed init-then-recycle scheme it adds a runtime channel count, re-init/flush, per-channel busy tracking, occupancy count, and detection of illegal releases.

## Interface
- CHANNEL_NUM_TOTAL, 64: maximum channel count; also the free-list depth.
- CHANNEL_NUM_WIDTH, $clog2(CHANNEL_NUM_TOTAL): channel ID width (W).
- INIT_DELAY, 8: cycles spent in IDLE after reset before INIT begins.
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_chan_num  in  W+1  number of enabled channels N; sampled on INIT entry.
- init_start  in  1  single-cycle pulse; flushes the pool and restarts INIT.
- alloc_valid  out  1  a free ID is available.
- alloc_id  out  W  head of the free list; 0 whenever alloc_valid=0.
- alloc_ready  in  1  consumer takes alloc_id when alloc_valid & alloc_ready.
- release_valid  in  1  return a channel ID.
- release_id  in  W  ID being returned.
- busy_map  out  CHANNEL_NUM_TOTAL  bit i=1 means ID i is allocated.
- free_count  out  W+1  number of IDs in the free list.
- init_done  out  1  high while in RUN.
- err_double_release  out  1  one-cycle pulse.
- err_invalid_release  out  1  one-cycle pulse.

## Operation
- States: IDLE, INIT, RUN.
- IDLE:
  - delay counter runs INIT_DELAY cycles, then the FSM moves to INIT.
- INIT entry:
  - latch N = cfg_chan_num, clamped: 0 → TOTAL, values > TOTAL → TOTAL.
  - clear the free list, busy_map and the sweep counter.
- INIT sweep:
  - write IDs 0..N-1, one per cycle, in ascending order.
  - after the write of ID N-1, go to RUN.
- RUN:
  - alloc handshake pops the head ID and sets busy_map[id].
  - a release is legal only if release_id < N and busy_map[release_id]=1.
  - legal release: push release_id (combinational legality check, write same edge) and clear its busy bit.
  - release_id ≥ N: release dropped, err_invalid_release pulses.
  - release of an ID with busy=0: release dropped, err_double_release pulses.
- Outside RUN:
  - alloc_valid is forced to 0.
  - any release_valid is dropped and err_invalid_release pulses.
- init_start:
  - in any state other than IDLE, goes to INIT (re-entry counts as entry: relatch N and clear everything).
  - in IDLE it is ignored.
- Simultaneous alloc and legal release: both take effect; free_count is unchanged.
- Same-ID alloc/release in one cycle cannot occur: an allocatable ID is by definition not busy.
- The free list can never overflow, because the busy check bounds pushes. A full-write attempt is an assertion failure.
- free_count tracks pushes and pops; in RUN, free_count + popcount(busy_map) = N always holds.

## Timing
- Reset values: FSM = IDLE; all outputs 0; delay counter, sweep counter and free list cleared.
- IDLE lasts exactly INIT_DELAY cycles after the reset release edge.
- INIT lasts N cycles. init_done rises on the edge after the last write.
- alloc_valid=1 and alloc_id=0 hold in the first RUN cycle.
- Allocation on edge E:
  - alloc_id shows the next head after E.
  - busy bit sets and free_count decrements after E.
- Release on edge E: the ID is pushed at E. If the list was empty, alloc_valid rises after E (FWFT, one-edge latency).
- Error pulses are registered: high for the single cycle after the offending edge.
- Reset mid-operation: everything returns to reset values and the full IDLE delay repeats.
- init_start on edge E: INIT is entered after E. A handshake on E is discarded.

## Structure
- Shared package sha1_pkg:
  - chan_state_e enum {IDLE, INIT, RUN}.
  - CHANNEL_NUM_TOTAL default and derived widths, INIT_DELAY default.
- Sub-module sha1_free_list_fifo: FWFT, depth CHANNEL_NUM_TOTAL, width W, synchronous clear, occupancy output.
- Top module holds the FSM, delay/sweep counters, N latch, busy_map, legality check and error registers.

## Test plan
- Reset, N=64, alloc_ready=0:
  - init_done rises 8+64 cycles after reset release.
  - free_count=64, alloc_id=0.
- N=4, alloc_ready held 1:
  - alloc IDs 0,1,2,3 on consecutive cycles, then alloc_valid=0.
  - busy_map=0xF, free_count=0.
- From that state, release 2 then 0:
  - alloc_valid rises one edge after the release of 2.
  - next allocs return 2 then 0 (FIFO order).
- Double release of ID 2, and release of ID 9 with N=4:
  - both releases are dropped.
  - err_double_release and err_invalid_release each pulse for one cycle.
  - free_count is unchanged.
- Simultaneous alloc and legal release every cycle for 100 cycles: free_count stays constant and the invariant holds.
- init_start mid-RUN with cfg_chan_num=0:
  - busy_map clears.
  - 64-cycle INIT runs.
  - a release arriving during INIT is dropped with err_invalid_release.
  - init_done returns, with free_count=64.

Source files
------------

// File: rtl/sha1_pkg.sv
// sha1_pkg
// Shared definitions for the SHA1 channel pool: the pool FSM state encoding
// and the default sizing parameters used by the pool and its free list.
package sha1_pkg;

    localparam int CHANNEL_NUM_TOTAL_DEF = 64;
    localparam int CHANNEL_NUM_WIDTH_DEF = $clog2(CHANNEL_NUM_TOTAL_DEF);
    localparam int INIT_DELAY_DEF        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } chan_state_e;

endpackage

// File: rtl/sha1_free_list_fifo.sv
// sha1_free_list_fifo
// First-word-fall-through FIFO holding free channel IDs.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_clr           synchronous flush (wins over push/pop)
//   i_push          write i_push_data at the tail
//   i_push_data     ID to store
//   i_pop           drop the head (caller guarantees o_valid)
//   o_valid         list not empty; o_head is meaningful
//   o_head          current head entry
//   o_count         number of stored entries
module sha1_free_list_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 6,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clr && i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // The owner bounds pushes by its busy tracking, so a write into a full
    // list means that bookkeeping has been broken.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clr) begin
            assert (!(i_push && !i_pop && r_count == CW'(DEPTH)));
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sha1_channel_pool.sv
// sha1_channel_pool
// Free-list allocator for SHA1 engine channel IDs. After reset it waits
// INIT_DELAY cycles, loads IDs 0..N-1 into the free list, then hands IDs out
// and takes them back, tracking which IDs are outstanding.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cfg_chan_num               channel count N (0 or >TOTAL means TOTAL)
//   init_start                 pulse: flush and reload (ignored in IDLE)
//   alloc_valid/ready/id       ID hand-out port
//   release_valid/id           ID return port (no back-pressure)
//   busy_map                   bit i set while ID i is allocated
//   free_count                 IDs currently in the free list
//   init_done                  high in RUN
//   err_double_release         pulse: returned ID was not allocated
//   err_invalid_release        pulse: ID >= N, or release outside RUN
//   dbg_state                  current FSM state
// Handshake: an ID transfers on a rising edge where alloc_valid and
// alloc_ready are both 1; alloc_valid never depends on alloc_ready, and
// alloc_id holds 0 whenever alloc_valid is 0. Releases are accepted or
// flagged on the edge where release_valid is 1.
module sha1_channel_pool
    import sha1_pkg::*;
#(
    parameter int CHANNEL_NUM_TOTAL = CHANNEL_NUM_TOTAL_DEF,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL),
    parameter int INIT_DELAY        = INIT_DELAY_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNEL_NUM_WIDTH:0]   cfg_chan_num,
    input  logic                         init_start,
    output logic                         alloc_valid,
    output logic [CHANNEL_NUM_WIDTH-1:0] alloc_id,
    input  logic                         alloc_ready,
    input  logic                         release_valid,
    input  logic [CHANNEL_NUM_WIDTH-1:0] release_id,
    output logic [CHANNEL_NUM_TOTAL-1:0] busy_map,
    output logic [CHANNEL_NUM_WIDTH:0]   free_count,
    output logic                         init_done,
    output logic                         err_double_release,
    output logic                         err_invalid_release,
    output chan_state_e                  dbg_state
);
    localparam int W  = CHANNEL_NUM_WIDTH;
    localparam int NW = W + 1;
    localparam int DW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam logic [NW-1:0] TOTAL_N = NW'(CHANNEL_NUM_TOTAL);

    chan_state_e                  r_state;
    logic [DW-1:0]                r_delay_cnt;
    logic [NW-1:0]                r_sweep;
    logic [NW-1:0]                r_n;
    logic [CHANNEL_NUM_TOTAL-1:0] r_busy;
    logic                         r_init_done;
    logic                         r_err_dbl;
    logic                         r_err_inv;

    logic          w_delay_done;
    logic          w_enter_init;
    logic          w_in_run;
    logic          w_id_in_range;
    logic          w_id_busy;
    logic          w_rel_legal;
    logic          w_alloc_fire;
    logic          w_push;
    logic          w_fifo_valid;
    logic [W-1:0]  w_head;
    logic [W-1:0]  w_push_data;
    logic [NW-1:0] w_n_clamped;
    logic [NW-1:0] w_free_count;

    assign w_n_clamped  = (cfg_chan_num == '0 || cfg_chan_num > TOTAL_N) ? TOTAL_N : cfg_chan_num;
    assign w_delay_done = (r_delay_cnt == DW'(INIT_DELAY - 1));
    // Entry into INIT, both the timed one from IDLE and a restart pulse.
    assign w_enter_init = (r_state == IDLE) ? w_delay_done : init_start;
    assign w_in_run     = (r_state == RUN);

    assign w_id_in_range = ({1'b0, release_id} < r_n);
    assign w_id_busy     = r_busy[release_id];
    // A restart pulse discards any handshake on the same edge.
    assign w_rel_legal   = release_valid && w_in_run && !init_start && w_id_in_range && w_id_busy;
    assign w_alloc_fire  = w_in_run && !init_start && w_fifo_valid && alloc_ready;

    assign w_push      = ((r_state == INIT) && !init_start) || w_rel_legal;
    assign w_push_data = (r_state == INIT) ? r_sweep[W-1:0] : release_id;

    sha1_free_list_fifo #(
        .DEPTH (CHANNEL_NUM_TOTAL),
        .WIDTH (W),
        .CW    (NW)
    ) u_free_list (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_enter_init),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_alloc_fire),
        .o_valid     (w_fifo_valid),
        .o_head      (w_head),
        .o_count     (w_free_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_delay_cnt <= '0;
            r_sweep     <= '0;
            r_n         <= '0;
            r_busy      <= '0;
            r_init_done <= 1'b0;
        end else if (w_enter_init) begin
            r_state     <= INIT;
            r_delay_cnt <= '0;
            r_sweep     <= '0;
            r_n         <= w_n_clamped;
            r_busy      <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_delay_cnt <= r_delay_cnt + DW'(1);
                INIT: begin
                    r_sweep <= r_sweep + NW'(1);
                    if (r_sweep == r_n - NW'(1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    // Alloc and legal release never name the same ID: the
                    // head of the free list is by construction not busy.
                    if (w_alloc_fire) r_busy[w_head]     <= 1'b1;
                    if (w_rel_legal)  r_busy[release_id] <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_dbl <= 1'b0;
            r_err_inv <= 1'b0;
        end else begin
            r_err_inv <= release_valid && (!w_in_run || !w_id_in_range);
            r_err_dbl <= release_valid && w_in_run && w_id_in_range && !w_id_busy;
        end
    end

    assign alloc_valid         = w_in_run && w_fifo_valid;
    assign alloc_id            = alloc_valid ? w_head : '0;
    assign busy_map            = r_busy;
    assign free_count          = w_free_count;
    assign init_done           = r_init_done;
    assign err_double_release  = r_err_dbl;
    assign err_invalid_release = r_err_inv;
    assign dbg_state           = r_state;

endmodule
